// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the FIFO.
// master: producer/FIFO side; slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic [CNT_W-1:0]  fifo_words;
    logic              wr_en;
    logic [DATA_W-1:0] fifo_data;
    logic              stalled;
    logic [15:0]       wr_count;

    modport master (
        output req0, data0, req1, data1, fifo_words,
        input  gnt0, gnt1, wr_en, fifo_data, stalled, wr_count
    );

    modport slave (
        input  req0, data0, req1, data1, fifo_words,
        output gnt0, gnt1, wr_en, fifo_data, stalled, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the FIFO write port, throttled by
// high/low watermarks on FIFO occupancy plus the in-flight write.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 4,
    parameter int HIGH_MARK = 5,
    parameter int LOW_MARK  = 2
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {
        RUN,
        PAUSE
    } state_t;

    localparam logic [CNT_W:0]   HIGH_LVL = (CNT_W+1)'(HIGH_MARK);
    localparam logic [CNT_W-1:0] LOW_LVL  = CNT_W'(LOW_MARK);

    state_t            state;
    logic              last;
    logic              wr_en_q;
    logic [DATA_W-1:0] data_q;
    logic              stalled_q;
    logic [15:0]       count_q;

    logic [CNT_W:0]    level;
    logic              eligible;
    logic              g0;
    logic              g1;

    // level includes the write registered last cycle but not yet seen in fifo_words
    always_comb begin
        level    = {1'b0, bus.fifo_words} + {{CNT_W{1'b0}}, wr_en_q};
        eligible = !rst && (state == RUN) && (level < HIGH_LVL);
        g0       = eligible && bus.req0 && (!bus.req1 || last);
        g1       = eligible && bus.req1 && (!bus.req0 || !last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            last      <= 1'b1;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            stalled_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (wr_en_q) begin
                count_q <= count_q + 16'd1;
            end
            case (state)
                RUN: begin
                    if (level >= HIGH_LVL) begin
                        state     <= PAUSE;
                        stalled_q <= 1'b1;
                        wr_en_q   <= 1'b0;
                    end else begin
                        wr_en_q <= g0 | g1;
                        if (g0) begin
                            data_q <= bus.data0;
                            last   <= 1'b0;
                        end else if (g1) begin
                            data_q <= bus.data1;
                            last   <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    wr_en_q <= 1'b0;
                    if (bus.fifo_words <= LOW_LVL) begin
                        state     <= RUN;
                        stalled_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = g0;
    assign bus.gnt1      = g1;
    assign bus.wr_en     = wr_en_q;
    assign bus.fifo_data = data_q;
    assign bus.stalled   = stalled_q;
    assign bus.wr_count  = count_q;
endmodule
